// File: rtl/raw_bayer_to_rgb888.sv
// RAW8 Bayer to RGB888 using a 2x2 nearest-neighbour demosaic over one line buffer.
// Three register stages (window/read, channel select, output); the sync signals ride a matching 3-deep shift.
module raw_bayer_to_rgb888 #(
  parameter int IMG_HDISP     = 640,
  parameter int BAYER_PATTERN = 0
) (
  input  logic       cmos_pclk,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [7:0] per_img_raw,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic [7:0] post_img_red,
  output logic [7:0] post_img_green,
  output logic [7:0] post_img_blue,
  output logic       line_len_err
);
  localparam int CW = $clog2(IMG_HDISP + 1);
  localparam int AW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam int RW = 11;
  localparam logic [CW-1:0] HDISP = CW'(IMG_HDISP);
  localparam logic [1:0]    BP    = 2'(BAYER_PATTERN);

  logic          vs_prev_q, vs_prev_d, href_prev_q, href_prev_d, armed_q, armed_d;
  logic [CW-1:0] col_q, col_d;
  logic          col_ovf_q, col_ovf_d, err_q, err_d;
  logic [RW-1:0] row_q, row_d;
  logic          vs_rise, href_fall, accept, in_rng, wr_en;
  logic [AW-1:0] wr_addr;

  logic [7:0]    tl_q, tl_d, bl_q, bl_d, br_q, br_d, tr_q;
  logic          s1_ok_q, s1_ok_d, s1_edge_q, s1_edge_d;
  logic [1:0]    s1_ph_q, s1_ph_d;
  logic [7:0]    s2_red_q, s2_red_d, s2_grn_q, s2_grn_d, s2_blu_q, s2_blu_d;
  logic [7:0]    red_q, red_d, grn_q, grn_d, blu_q, blu_d;
  logic [2:0][2:0] sync_q, sync_d;   // each entry: {vsync, href, clken}

  logic [7:0]    line_mem [IMG_HDISP];
  logic [7:0]    win [4];
  logic [1:0]    k;
  logic [8:0]    gsum;

  // Input-side counters. vs_prev resets high so a frame already in flight at reset release is ignored.
  always_comb begin
    vs_rise     = per_frame_vsync & ~vs_prev_q;
    href_fall   = ~per_frame_href & href_prev_q;
    vs_prev_d   = per_frame_vsync;
    href_prev_d = per_frame_href;
    armed_d     = armed_q;
    if (vs_rise)               armed_d = 1'b1;
    else if (!per_frame_vsync) armed_d = 1'b0;
    accept  = armed_d & per_frame_href & per_frame_clken;
    in_rng  = (col_q < HDISP);
    wr_en   = accept & in_rng;
    wr_addr = col_q[AW-1:0];

    col_d = col_q;
    if (!per_frame_href || vs_rise) col_d = '0;
    else if (wr_en)                 col_d = col_q + CW'(1);

    col_ovf_d = col_ovf_q;
    if (!per_frame_href)       col_ovf_d = 1'b0;
    else if (accept && !in_rng) col_ovf_d = 1'b1;

    row_d = row_q;
    if (vs_rise)                   row_d = '0;
    else if (href_fall && armed_d) row_d = row_q + RW'(1);

    err_d = err_q;
    if (vs_rise) err_d = 1'b0;
    else if (href_fall && armed_d && ((col_q != HDISP) || col_ovf_q)) err_d = 1'b1;
  end

  // Line buffer: read-first so tr_q sees the previous line at this column.
  always_ff @(posedge cmos_pclk) begin
    if (wr_en) begin
      tr_q              <= line_mem[wr_addr];
      line_mem[wr_addr] <= per_img_raw;
    end
  end

  always_comb begin
    tl_d      = wr_en ? tr_q        : tl_q;
    bl_d      = wr_en ? br_q        : bl_q;
    br_d      = wr_en ? per_img_raw : br_q;
    s1_ok_d   = wr_en;
    s1_edge_d = (row_q == '0) || (col_q == '0);
    s1_ph_d   = {row_q[0], col_q[0]};
    sync_d[0] = {per_frame_vsync, per_frame_href, per_frame_clken};
    sync_d[1] = sync_q[0];
    sync_d[2] = sync_q[1];
  end

  // Window index 0..3 = BR, BL, TR, TL; the element whose offset equals phase^pattern holds red.
  always_comb begin
    win[0] = br_q;
    win[1] = bl_q;
    win[2] = tr_q;
    win[3] = tl_q;
    k      = s1_ph_q ^ BP;
    gsum   = {1'b0, win[k ^ 2'd1]} + {1'b0, win[k ^ 2'd2]};
    s2_red_d = '0;
    s2_grn_d = '0;
    s2_blu_d = '0;
    if (s1_ok_q) begin
      if (s1_edge_q) begin
        s2_red_d = br_q;
        s2_grn_d = br_q;
        s2_blu_d = br_q;
      end else begin
        s2_red_d = win[k];
        s2_grn_d = gsum[8:1];
        s2_blu_d = win[k ^ 2'd3];
      end
    end
    red_d = (sync_q[1][1] && sync_q[1][0]) ? s2_red_q : '0;
    grn_d = (sync_q[1][1] && sync_q[1][0]) ? s2_grn_q : '0;
    blu_d = (sync_q[1][1] && sync_q[1][0]) ? s2_blu_q : '0;
  end

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev_q   <= 1'b1;
      href_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      col_q       <= '0;
      col_ovf_q   <= 1'b0;
      row_q       <= '0;
      err_q       <= 1'b0;
      tl_q        <= '0;
      bl_q        <= '0;
      br_q        <= '0;
      s1_ok_q     <= 1'b0;
      s1_edge_q   <= 1'b0;
      s1_ph_q     <= '0;
      s2_red_q    <= '0;
      s2_grn_q    <= '0;
      s2_blu_q    <= '0;
      red_q       <= '0;
      grn_q       <= '0;
      blu_q       <= '0;
      sync_q      <= '0;
    end else begin
      vs_prev_q   <= vs_prev_d;
      href_prev_q <= href_prev_d;
      armed_q     <= armed_d;
      col_q       <= col_d;
      col_ovf_q   <= col_ovf_d;
      row_q       <= row_d;
      err_q       <= err_d;
      tl_q        <= tl_d;
      bl_q        <= bl_d;
      br_q        <= br_d;
      s1_ok_q     <= s1_ok_d;
      s1_edge_q   <= s1_edge_d;
      s1_ph_q     <= s1_ph_d;
      s2_red_q    <= s2_red_d;
      s2_grn_q    <= s2_grn_d;
      s2_blu_q    <= s2_blu_d;
      red_q       <= red_d;
      grn_q       <= grn_d;
      blu_q       <= blu_d;
      sync_q      <= sync_d;
    end
  end

  assign post_frame_vsync = sync_q[2][2];
  assign post_frame_href  = sync_q[2][1];
  assign post_frame_clken = sync_q[2][0];
  assign post_img_red     = red_q;
  assign post_img_green   = grn_q;
  assign post_img_blue    = blu_q;
  assign line_len_err     = err_q;
endmodule
